wave_generator_param: RTL and testbench
=======================================

// Module: wave_generator_param
//
// PURPOSE
//  Parametrised multi-mode waveform generator: square (programmable period/duty),
//  sawtooth and triangle, each with programmable amplitude and step. Drives a
//  WIDTH-bit sample stream to downstream DAC/logging logic, one sample per clk.
//  Configuration is shadowed and applied only at period boundaries, so there are
//  no glitched periods.
//
// PARAMETERS
//  WIDTH  8   sample width; amp, step and wave are WIDTH bits
//  CNT_W  16  square-mode counter width; sq_period and sq_high are CNT_W bits
//
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  en         in   1      1 = run, 0 = idle (output forced to 0)
//  wave_sel   in   2      00 square, 01 sawtooth, 10 triangle, 11 off
//  amp        in   WIDTH  peak sample value
//  step       in   WIDTH  saw/triangle increment per cycle (0 treated as 1)
//  sq_period  in   CNT_W  square period in cycles (0 treated as 1)
//  sq_high    in   CNT_W  square high cycles (>= sq_period gives constant amp)
//  wave       out  WIDTH  registered sample
//  period_st  out  1      1-cycle pulse, coincident with the first sample of each period
//  busy       out  1      1 while in RUN
//
// BEHAVIOUR
//  - Reset: rst_n sampled low at a clk edge sets wave=0, period_st=0, busy=0,
//    state=IDLE, counters=0 and shadow config=0. Reset overrides all other activity,
//    mid-period included.
//  - States: IDLE, RUN.
//  - IDLE: wave=0, period_st=0, busy=0. Shadow config (sel/amp/step/period/high)
//    reloads from the inputs every cycle.
//  - IDLE->RUN: on the edge where en=1. First sample is registered on that same edge
//    with period_st=1. The first sample is amp for square with sq_high>0, else 0.
//  - RUN->IDLE: on the edge where en=0, with wave<=0 on that edge. No partial-period
//    completion.
//  - Shadow reload in RUN: only on the edge that emits a period_st sample. That sample
//    is already computed with the new config. Input changes mid-period are ignored
//    until that edge.
//  - Square (00): cnt runs 0..P-1 and wraps, with P=max(sq_period,1).
//    wave = (cnt<sq_high) ? amp : 0.
//    period_st=1 on every sample with cnt==0.
//  - Sawtooth (01): with s=max(step,1), next = (wave+s > amp) ? 0 : wave+s.
//    The sum is evaluated in WIDTH+1 bits, so there is no wrap.
//    period_st=1 on every 0 that follows a wrap.
//  - Triangle (10): dir flag, initially up. Again s=max(step,1).
//    up:   if wave+s >= amp (WIDTH+1 bits), next=amp and dir=down; else next=wave+s.
//    down: if wave <= s, next=0, dir=up and period_st=1; else next=wave-s.
//    amp=0 gives the sequence 0,0,... with period_st every 2nd cycle.
//  - Off (11): wave=0 and period_st=0 while busy=1. Shadow reloads every cycle, so
//    leaving mode 11 starts a new period on the next edge with period_st=1.
//  - Mode change to any other mode takes effect at the next boundary only; counters
//    and dir restart at that boundary.
//  - Latency: config at boundary to first new sample = 0 extra cycles (same edge).
//    en to first sample = 1 edge.
//
// TESTING
//  1. Reset with en=1 held: wave=0, busy=0 throughout. Release -> next edge wave=first
//     sample, period_st=1.
//  2. Square: amp=20, P=4, high=1 -> 20,0,0,0,20,0...; period_st on each 20.
//     high=4 -> constant 20.
//  3. Sawtooth: amp=10, step=3 -> 0,3,6,9,0,3...; period_st on each 0.
//     step=0 behaves as step=1: 0..10,0.
//  4. Triangle: amp=6, step=2 -> 0,2,4,6,4,2,0,2...; period_st on each 0.
//     amp=255, step=200 (WIDTH=8) -> 0,200,255,55,0 with no overflow.
//  5. Sawtooth amp=10, step=1: change amp to 5 at sample 4 -> continues 5..10, then
//     0,1..5. New amp applies only from the boundary.
//  6. Drop en mid-period -> wave=0 next edge, busy=0. rst_n low mid-triangle ->
//     outputs zero; restart begins up from 0.

Source files
------------

// File: rtl/wave_generator_param_if.sv
// Configuration and sample-stream bundle for the multi-mode wave generator.
// The master drives configuration and consumes samples; the generator is the slave.
interface wave_generator_param_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic [1:0]       wave_sel;
    logic [WIDTH-1:0] amp;
    logic [WIDTH-1:0] step;
    logic [CNT_W-1:0] sq_period;
    logic [CNT_W-1:0] sq_high;
    logic [WIDTH-1:0] wave;
    logic             period_st;
    logic             busy;

    modport master (
        output en, wave_sel, amp, step, sq_period, sq_high,
        input  wave, period_st, busy
    );

    modport slave (
        input  en, wave_sel, amp, step, sq_period, sq_high,
        output wave, period_st, busy
    );
endinterface

// File: rtl/wave_generator_param.sv
// Square / sawtooth / triangle sample generator, one registered sample per clk.
// Config is shadowed and only swapped on the edge that emits a period-start sample.
module wave_generator_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wave_generator_param_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [1:0] SEL_SQ  = 2'b00;
    localparam logic [1:0] SEL_SAW = 2'b01;
    localparam logic [1:0] SEL_TRI = 2'b10;
    localparam logic [1:0] SEL_OFF = 2'b11;

    state_t state, state_nx;

    logic [1:0]       sh_sel;
    logic [WIDTH-1:0] sh_amp, sh_step;
    logic [CNT_W-1:0] sh_period, sh_high;

    logic [CNT_W-1:0] cnt;
    logic             dir_dn;
    logic [WIDTH-1:0] wave_q;
    logic             pst_q;

    logic [CNT_W-1:0] cnt_nx;
    logic             dir_nx;
    logic [WIDTH-1:0] wave_nx;
    logic             pst_nx;
    logic             reload;

    // continuation of the running period under the shadow config
    logic [WIDTH-1:0] s_sh;
    logic [CNT_W-1:0] p_sh;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_wrap;
    logic [WIDTH:0]   sum;
    logic [CNT_W-1:0] cont_cnt;
    logic             cont_dir;
    logic [WIDTH-1:0] cont_wave;
    logic             bnd;

    // first sample of a period under the live input config
    logic [WIDTH-1:0] st_wave;
    logic             st_pst;

    assign s_sh     = (sh_step == '0) ? WIDTH'(1) : sh_step;
    assign p_sh     = (sh_period == '0) ? CNT_W'(1) : sh_period;
    assign cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
    assign cnt_wrap = (cnt_inc >= {1'b0, p_sh}) ? '0 : cnt_inc[CNT_W-1:0];
    assign sum      = {1'b0, wave_q} + {1'b0, s_sh};

    always_comb begin
        cont_cnt  = '0;
        cont_dir  = dir_dn;
        cont_wave = '0;
        bnd       = 1'b0;
        case (sh_sel)
            SEL_SQ: begin
                cont_cnt  = cnt_wrap;
                cont_wave = (cnt_wrap < sh_high) ? sh_amp : '0;
                bnd       = (cnt_wrap == '0);
            end
            SEL_SAW: begin
                if (sum > {1'b0, sh_amp}) bnd = 1'b1;
                else                      cont_wave = sum[WIDTH-1:0];
            end
            SEL_TRI: begin
                if (!dir_dn) begin
                    if (sum >= {1'b0, sh_amp}) begin
                        cont_wave = sh_amp;
                        cont_dir  = 1'b1;
                    end else begin
                        cont_wave = sum[WIDTH-1:0];
                    end
                end else if (wave_q <= s_sh) begin
                    bnd = 1'b1;
                end else begin
                    cont_wave = wave_q - s_sh;
                end
            end
            // off mode re-evaluates the live config every cycle
            default: bnd = 1'b1;
        endcase
    end

    always_comb begin
        st_wave = '0;
        if (bus.wave_sel == SEL_SQ && bus.sq_high != '0) st_wave = bus.amp;
        st_pst = (bus.wave_sel != SEL_OFF);
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.en)  state_nx = RUN;
            RUN:     if (!bus.en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // next sample / counters; reload marks a shadow swap on this edge
    always_comb begin
        wave_nx = '0;
        pst_nx  = 1'b0;
        cnt_nx  = '0;
        dir_nx  = 1'b0;
        reload  = 1'b1;
        if (state_nx == RUN) begin
            if (state == IDLE || bnd) begin
                wave_nx = st_wave;
                pst_nx  = st_pst;
            end else begin
                wave_nx = cont_wave;
                cnt_nx  = cont_cnt;
                dir_nx  = cont_dir;
                reload  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wave_q    <= '0;
            pst_q     <= 1'b0;
            cnt       <= '0;
            dir_dn    <= 1'b0;
            sh_sel    <= '0;
            sh_amp    <= '0;
            sh_step   <= '0;
            sh_period <= '0;
            sh_high   <= '0;
        end else begin
            wave_q <= wave_nx;
            pst_q  <= pst_nx;
            cnt    <= cnt_nx;
            dir_dn <= dir_nx;
            if (reload) begin
                sh_sel    <= bus.wave_sel;
                sh_amp    <= bus.amp;
                sh_step   <= bus.step;
                sh_period <= bus.sq_period;
                sh_high   <= bus.sq_high;
            end
        end
    end

    assign bus.wave      = wave_q;
    assign bus.period_st = pst_q;
    assign bus.busy      = (state == RUN);
endmodule

// File: tb/tb_wave_generator_param.sv
// Directed bench for wave_generator_param: hand-derived sample sequences per mode.
// Expected samples are encoded as value + PS when period_st must be high.
module tb_wave_generator_param;
    localparam int PS = 1000;

    logic clk = 1'b0;
    logic rst_n;
    int   errs = 0;
    int   nchk = 0;

    wave_generator_param_if #(.WIDTH(8), .CNT_W(16)) bus ();

    wave_generator_param #(.WIDTH(8), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stp(input string tag, input int e);
        tick();
        chk({tag, ".wave"}, int'(bus.wave), e % PS);
        chk({tag, ".pst"},  int'(bus.period_st), int'(e >= PS));
        chk({tag, ".busy"}, int'(bus.busy), 1);
    endtask

    task automatic idle_chk(input string tag);
        tick();
        chk({tag, ".wave"}, int'(bus.wave), 0);
        chk({tag, ".pst"},  int'(bus.period_st), 0);
        chk({tag, ".busy"}, int'(bus.busy), 0);
    endtask

    task automatic cfg(input logic [1:0] sel, input int a, input int s,
                       input int p, input int h);
        bus.wave_sel  = sel;
        bus.amp       = 8'(a);
        bus.step      = 8'(s);
        bus.sq_period = 16'(p);
        bus.sq_high   = 16'(h);
    endtask

    initial begin
        rst_n  = 1'b0;
        bus.en = 1'b1;
        cfg(2'b00, 20, 1, 4, 1);

        // reset holds everything at zero even with en high
        idle_chk("rst0"); idle_chk("rst1"); idle_chk("rst2");
        rst_n = 1'b1;

        // square P=4 high=1, then high=4 requested mid-period
        stp("sq", PS+20); stp("sq", 0); stp("sq", 0); stp("sq", 0);
        stp("sq", PS+20); stp("sq", 0);
        bus.sq_high = 16'd4;
        stp("sqh", 0); stp("sqh", 0); stp("sqh", PS+20); stp("sqh", 20);
        stp("sqh", 20); stp("sqh", 20); stp("sqh", PS+20);
        bus.en = 1'b0; idle_chk("sq_off");

        // sawtooth amp=10 step=3
        cfg(2'b01, 10, 3, 4, 1); bus.en = 1'b1;
        stp("saw", PS+0); stp("saw", 3); stp("saw", 6); stp("saw", 9);
        stp("saw", PS+0); stp("saw", 3);
        bus.en = 1'b0; idle_chk("saw_off");

        // step=0 treated as 1
        cfg(2'b01, 10, 0, 4, 1); bus.en = 1'b1;
        stp("saw0", PS+0);
        for (int i = 1; i <= 10; i++) stp("saw0", i);
        stp("saw0", PS+0);
        bus.en = 1'b0; idle_chk("saw0_off");

        // triangle amp=6 step=2
        cfg(2'b10, 6, 2, 4, 1); bus.en = 1'b1;
        stp("tri", PS+0); stp("tri", 2); stp("tri", 4); stp("tri", 6);
        stp("tri", 4); stp("tri", 2); stp("tri", PS+0); stp("tri", 2);
        bus.en = 1'b0; idle_chk("tri_off");

        // triangle near full scale: no overflow past 255
        cfg(2'b10, 255, 200, 4, 1); bus.en = 1'b1;
        stp("trimax", PS+0); stp("trimax", 200); stp("trimax", 255);
        stp("trimax", 55); stp("trimax", PS+0);
        bus.en = 1'b0; idle_chk("trimax_off");

        // amp change mid-period applies only from the next boundary
        cfg(2'b01, 10, 1, 4, 1); bus.en = 1'b1;
        for (int i = 0; i < 5; i++) stp("sawamp", (i == 0) ? PS : i);
        bus.amp = 8'd5;
        for (int i = 5; i <= 10; i++) stp("sawamp", i);
        stp("sawamp", PS+0);
        for (int i = 1; i <= 5; i++) stp("sawamp", i);
        stp("sawamp", PS+0);
        bus.en = 1'b0; idle_chk("sawamp_off");

        // mode change waits for the square boundary; off mode then restart
        cfg(2'b00, 20, 1, 3, 2); bus.en = 1'b1;
        stp("mode", PS+20);
        bus.wave_sel = 2'b01; bus.amp = 8'd4; bus.step = 8'd2;
        stp("mode", 20); stp("mode", 0);
        stp("mode", PS+0); stp("mode", 2); stp("mode", 4); stp("mode", PS+0);
        bus.wave_sel = 2'b11;
        stp("moff", 2); stp("moff", 4); stp("moff", 0); stp("moff", 0);
        bus.wave_sel = 2'b01;
        stp("mon", PS+0); stp("mon", 2);
        bus.en = 1'b0; idle_chk("mode_off");

        // en drop mid-period, then reset mid-triangle
        cfg(2'b10, 6, 2, 4, 1); bus.en = 1'b1;
        stp("tri6", PS+0); stp("tri6", 2); stp("tri6", 4);
        bus.en = 1'b0; idle_chk("tri6_en");
        bus.en = 1'b1;
        stp("tri6", PS+0); stp("tri6", 2); stp("tri6", 4); stp("tri6", 6);
        rst_n = 1'b0; idle_chk("tri6_rst");
        rst_n = 1'b1;
        stp("tri6r", PS+0); stp("tri6r", 2); stp("tri6r", 4);
        stp("tri6r", 6); stp("tri6r", 4);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
